// File: rtl/wfg_stim_sine_sweep_ctrl.sv
// Frequency-sweep sequencer: steps the wfg_stim_sine increment from start to stop, dwelling per accepted sample.
// Define WFG_SWEEP_BIDIR_EN to add cfg_bidir_i and an up-then-down (triangular) sweep.
module wfg_stim_sine_sweep_ctrl #(
    parameter int INCW   = 16,
    parameter int DWELLW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [INCW-1:0]   cfg_start_inc_i,
    input  logic [INCW-1:0]   cfg_stop_inc_i,
    input  logic [INCW-1:0]   cfg_step_i,
    input  logic [DWELLW-1:0] cfg_dwell_i,
    input  logic              cfg_repeat_i,
`ifdef WFG_SWEEP_BIDIR_EN
    input  logic              cfg_bidir_i,
`endif
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              wfg_axis_tvalid_i,
    input  logic              wfg_axis_tready_i,
    output logic              ctrl_en_o,
    output logic [INCW-1:0]   inc_val_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [INCW-1:0]   r_start;
    logic [INCW-1:0]   r_stop;
    logic [INCW-1:0]   r_step;
    logic [DWELLW-1:0] r_dwell;
    logic              r_repeat;

    logic [INCW-1:0]   r_inc_val;
    logic [INCW-1:0]   w_inc_val_next;
    logic [DWELLW-1:0] r_count;
    logic [DWELLW-1:0] w_count_next;
    logic              r_ctrl_en;
    logic              w_ctrl_en_next;
    logic              r_busy;
    logic              w_busy_next;
    logic              r_done;
    logic              w_done_next;

    logic              w_latch;
    logic              w_accept;
    logic [DWELLW-1:0] w_dwell_eff;
    logic [DWELLW-1:0] w_count_inc;
    logic              w_dwell_hit;
    logic [INCW:0]     w_sum;
    logic              w_up_ok;
    logic              w_adv_ok;
    logic [INCW-1:0]   w_adv_val;

`ifdef WFG_SWEEP_BIDIR_EN
    logic              r_bidir;
    logic              r_dir_down;
    logic              w_dir_down_next;
    logic              w_adv_down;
    logic [INCW:0]     w_diff;
    logic              w_down_ok;
`endif

    assign w_latch     = (r_state == ST_IDLE) && start_i && !abort_i;
    assign w_accept    = wfg_axis_tvalid_i && wfg_axis_tready_i;
    // A programmed dwell of zero behaves as a dwell of one sample.
    assign w_dwell_eff = (r_dwell == '0) ? DWELLW'(1) : r_dwell;
    assign w_count_inc = r_count + DWELLW'(1);
    assign w_dwell_hit = (w_count_inc == w_dwell_eff);
    assign w_sum       = {1'b0, r_inc_val} + {1'b0, r_step};
    assign w_up_ok     = (r_step != '0) && (w_sum <= {1'b0, r_stop});

`ifdef WFG_SWEEP_BIDIR_EN
    // The borrow bit catches underflow below zero as well as falling under start.
    assign w_diff      = {1'b0, r_inc_val} - {1'b0, r_step};
    assign w_down_ok   = (r_step != '0) && !w_diff[INCW] && (w_diff[INCW-1:0] >= r_start);
`endif

    always_comb begin
        w_adv_ok  = w_up_ok;
        w_adv_val = w_sum[INCW-1:0];
`ifdef WFG_SWEEP_BIDIR_EN
        w_adv_down = 1'b0;
        if (r_dir_down) begin
            w_adv_ok   = w_down_ok;
            w_adv_val  = w_diff[INCW-1:0];
            w_adv_down = 1'b1;
        end else if (!w_up_ok && r_bidir && w_down_ok) begin
            w_adv_ok   = 1'b1;
            w_adv_val  = w_diff[INCW-1:0];
            w_adv_down = 1'b1;
        end
`endif
    end

    always_comb begin
        w_state_next   = r_state;
        w_ctrl_en_next = r_ctrl_en;
        w_busy_next    = r_busy;
        w_done_next    = 1'b0;
        w_inc_val_next = r_inc_val;
        w_count_next   = r_count;
`ifdef WFG_SWEEP_BIDIR_EN
        w_dir_down_next = r_dir_down;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_latch) begin
                    w_state_next   = ST_RUN;
                    w_ctrl_en_next = 1'b1;
                    w_busy_next    = 1'b1;
                    w_inc_val_next = cfg_start_inc_i;
                    w_count_next   = '0;
`ifdef WFG_SWEEP_BIDIR_EN
                    w_dir_down_next = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                if (abort_i) begin
                    w_state_next   = ST_IDLE;
                    w_ctrl_en_next = 1'b0;
                    w_busy_next    = 1'b0;
                    w_count_next   = '0;
                end else if (w_accept) begin
                    if (!w_dwell_hit) begin
                        w_count_next = w_count_inc;
                    end else begin
                        w_count_next = '0;
                        if (w_adv_ok) begin
                            w_inc_val_next = w_adv_val;
`ifdef WFG_SWEEP_BIDIR_EN
                            w_dir_down_next = w_adv_down;
`endif
                        end else if (r_repeat) begin
                            w_inc_val_next = r_start;
`ifdef WFG_SWEEP_BIDIR_EN
                            w_dir_down_next = 1'b0;
`endif
                        end else begin
                            // inc_val is left at the final frequency.
                            w_state_next   = ST_DONE;
                            w_ctrl_en_next = 1'b0;
                            w_busy_next    = 1'b0;
                            w_done_next    = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                w_state_next   = ST_IDLE;
                w_ctrl_en_next = 1'b0;
                w_busy_next    = 1'b0;
            end
            default: begin
                w_state_next   = ST_IDLE;
                w_ctrl_en_next = 1'b0;
                w_busy_next    = 1'b0;
                w_count_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ctrl_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_inc_val <= '0;
            r_count   <= '0;
`ifdef WFG_SWEEP_BIDIR_EN
            r_dir_down <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_ctrl_en <= w_ctrl_en_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
            r_inc_val <= w_inc_val_next;
            r_count   <= w_count_next;
`ifdef WFG_SWEEP_BIDIR_EN
            r_dir_down <= w_dir_down_next;
`endif
        end
    end

    // Shadow copy of the configuration so mid-sweep register writes are invisible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start  <= '0;
            r_stop   <= '0;
            r_step   <= '0;
            r_dwell  <= '0;
            r_repeat <= 1'b0;
`ifdef WFG_SWEEP_BIDIR_EN
            r_bidir  <= 1'b0;
`endif
        end else if (w_latch) begin
            r_start  <= cfg_start_inc_i;
            r_stop   <= cfg_stop_inc_i;
            r_step   <= cfg_step_i;
            r_dwell  <= cfg_dwell_i;
            r_repeat <= cfg_repeat_i;
`ifdef WFG_SWEEP_BIDIR_EN
            r_bidir  <= cfg_bidir_i;
`endif
        end
    end

    assign ctrl_en_o = r_ctrl_en;
    assign inc_val_o = r_inc_val;
    assign busy_o    = r_busy;
    assign done_o    = r_done;

endmodule

// File: tb/tb_wfg_stim_sine_sweep_ctrl.sv
// Self-checking bench for wfg_stim_sine_sweep_ctrl: random handshakes against a sweep-list reference model.
// Define WFG_SWEEP_BIDIR_EN to also exercise the triangular sweep.
module tb_wfg_stim_sine_sweep_ctrl;

    localparam int INCW   = 16;
    localparam int DWELLW = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [INCW-1:0]   cfg_start;
    logic [INCW-1:0]   cfg_stop;
    logic [INCW-1:0]   cfg_step;
    logic [DWELLW-1:0] cfg_dwell;
    logic              cfg_repeat;
`ifdef WFG_SWEEP_BIDIR_EN
    logic              cfg_bidir;
`endif
    logic              start_i;
    logic              abort_i;
    logic              tvalid;
    logic              tready;
    logic              ctrl_en_o;
    logic [INCW-1:0]   inc_val_o;
    logic              busy_o;
    logic              done_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [INCW-1:0] hs_q[$];
    int              run_q[$];
    int              exp_steps[$];
    int              done_cnt;
    int              en_busy_err;
    bit              timed_out;
    logic            first_en;
    logic [INCW-1:0] first_val;

    wfg_stim_sine_sweep_ctrl #(.INCW(INCW), .DWELLW(DWELLW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cfg_start_inc_i   (cfg_start),
        .cfg_stop_inc_i    (cfg_stop),
        .cfg_step_i        (cfg_step),
        .cfg_dwell_i       (cfg_dwell),
        .cfg_repeat_i      (cfg_repeat),
`ifdef WFG_SWEEP_BIDIR_EN
        .cfg_bidir_i       (cfg_bidir),
`endif
        .start_i           (start_i),
        .abort_i           (abort_i),
        .wfg_axis_tvalid_i (tvalid),
        .wfg_axis_tready_i (tready),
        .ctrl_en_o         (ctrl_en_o),
        .inc_val_o         (inc_val_o),
        .busy_o            (busy_o),
        .done_o            (done_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // Reference model: the ordered list of frequencies a sweep visits.
    function automatic void build_steps(input int s, input int e, input int st, input bit bidir);
        int v;
        exp_steps.delete();
        v = s;
        exp_steps.push_back(v);
        if (st == 0) return;
        for (int n = v + st; n <= e; n += st) begin
            exp_steps.push_back(n);
            v = n;
        end
        if (bidir)
            for (int n = v - st; n >= s; n -= st) exp_steps.push_back(n);
    endfunction

    // Index of the first logged handshake whose frequency disagrees with the model, or -1.
    function automatic int log_mismatch(input int deff, input bit cyclic);
        for (int i = 0; i < hs_q.size(); i++) begin
            int k;
            k = i / deff;
            if (!cyclic && k >= exp_steps.size()) return i;
            if (hs_q[i] !== 16'(exp_steps[k % exp_steps.size()])) return i;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        start_i = 1'b0; abort_i = 1'b0; tvalid = 1'b0; tready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_sweep(input int s, input int e, input int st, input int dw, input bit rp);
        @(negedge clk);
        cfg_start = 16'(s); cfg_stop = 16'(e); cfg_step = 16'(st);
        cfg_dwell = 16'(dw); cfg_repeat = rp;
        start_i = 1'b1; abort_i = 1'b0; tvalid = 1'b0; tready = 1'b0;
    endtask

    // Drives handshakes (mode 0: always, 1: tready 0101.., 2: random) and logs what the DUT shows.
    task automatic collect(input int max_cycles, input int mode, input bit stop_on_done, input int poke_at);
        bit              seen_done;
        int              run_len;
        logic [INCW-1:0] last_val;
        seen_done = 0; run_len = 0; last_val = '0;
        hs_q.delete(); run_q.delete();
        done_cnt = 0; en_busy_err = 0; timed_out = 1;
        for (int n = 0; n < max_cycles; n++) begin
            @(negedge clk);
            start_i = 1'b0; abort_i = 1'b0;
            if (n == 0) begin first_en = ctrl_en_o; first_val = inc_val_o; end
            if (done_o === 1'b1) begin done_cnt++; seen_done = 1; end
            if (ctrl_en_o !== busy_o) en_busy_err++;
            if (busy_o === 1'b1) begin
                if (run_len > 0 && inc_val_o !== last_val) begin run_q.push_back(run_len); run_len = 0; end
                last_val = inc_val_o;
                run_len++;
            end else if (run_len > 0) begin
                run_q.push_back(run_len); run_len = 0;
            end
            if (stop_on_done && seen_done && done_o !== 1'b1) begin timed_out = 0; break; end
            case (mode)
                0: begin tvalid = 1'b1; tready = 1'b1; end
                1: begin tvalid = 1'b1; tready = (n % 2 == 1); end
                default: begin tvalid = ($urandom % 4) != 0; tready = ($urandom % 2) != 0; end
            endcase
            if (n == poke_at) begin
                start_i = 1'b1;
                cfg_start = 16'($urandom); cfg_stop = 16'($urandom);
                cfg_step = 16'($urandom); cfg_dwell = 16'($urandom_range(0, 5));
                cfg_repeat = 1'($urandom);
            end
            if (busy_o === 1'b1 && tvalid && tready) hs_q.push_back(inc_val_o);
        end
        if (run_len > 0) run_q.push_back(run_len);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_checks++;
        if ({ctrl_en_o, busy_o, done_o} !== 3'b000) $display("FAIL reset_flags: got en/busy/done=%b required 000", {ctrl_en_o, busy_o, done_o}); else n_pass++;
        n_checks++;
        if (inc_val_o !== 16'd0) $display("FAIL reset_inc: got %0d required 0", inc_val_o); else n_pass++;
        start_sweep(100, 400, 100, 3, 0);
        collect(4, 0, 0, -1);
        n_checks++;
        if (busy_o !== 1'b1) $display("FAIL reset_pre_busy: got %b required 1", busy_o); else n_pass++;
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ctrl_en_o, busy_o, done_o, inc_val_o} !== 19'd0)
            $display("FAIL reset_async: got en=%b busy=%b done=%b inc=%0d required all 0", ctrl_en_o, busy_o, done_o, inc_val_o);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tvalid = 1'b1; tready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ctrl_en_o, busy_o} !== 2'b00) $display("FAIL reset_idle_after: got en/busy=%b required 00", {ctrl_en_o, busy_o}); else n_pass++;
        tvalid = 1'b0; tready = 1'b0;
    endtask

    task automatic test_single_shot();
        int bad_runs;
        build_steps(100, 400, 100, 0);
        start_sweep(100, 400, 100, 3, 0);
        collect(200, 0, 1, -1);
        n_checks++;
        if (timed_out) $display("FAIL single_timeout: no done_o within 200 cycles"); else n_pass++;
        n_checks++;
        if (first_en !== 1'b1 || first_val !== 16'd100) $display("FAIL single_latency: got en=%b inc=%0d required en=1 inc=100", first_en, first_val); else n_pass++;
        n_checks++;
        if (hs_q.size() !== 12) $display("FAIL single_count: got %0d handshakes required 12", hs_q.size()); else n_pass++;
        n_checks++;
        if (log_mismatch(3, 0) !== -1) $display("FAIL single_seq: first wrong handshake index %0d required -1", log_mismatch(3, 0)); else n_pass++;
        bad_runs = 0;
        foreach (run_q[i]) if (run_q[i] != 3) bad_runs++;
        n_checks++;
        if (run_q.size() !== 4 || bad_runs !== 0) $display("FAIL single_runs: got %0d steps (%0d not 3 cycles) required 4 steps of 3", run_q.size(), bad_runs); else n_pass++;
        n_checks++;
        if (done_cnt !== 1) $display("FAIL single_done: got %0d done cycles required 1", done_cnt); else n_pass++;
        n_checks++;
        if (ctrl_en_o !== 1'b0 || en_busy_err !== 0) $display("FAIL single_en: got en=%b en/busy disagreements=%0d required 0/0", ctrl_en_o, en_busy_err); else n_pass++;
        n_checks++;
        if (inc_val_o !== 16'd400) $display("FAIL single_hold: got inc %0d required 400", inc_val_o); else n_pass++;
    endtask

    task automatic test_backpressure();
        int s, st, e, bad_runs;
        s = $urandom_range(0, 1000); st = $urandom_range(1, 300); e = s + st * $urandom_range(1, 4);
        build_steps(s, e, st, 0);
        start_sweep(s, e, st, 2, 0);
        collect(200, 1, 1, -1);
        bad_runs = 0;
        foreach (run_q[i]) if (run_q[i] != 4) bad_runs++;
        n_checks++;
        if (timed_out || run_q.size() !== exp_steps.size() || bad_runs !== 0)
            $display("FAIL backpressure_runs: got %0d steps (%0d not 4 cycles, timeout=%0b) required %0d steps of 4", run_q.size(), bad_runs, timed_out, exp_steps.size());
        else n_pass++;
        n_checks++;
        if (log_mismatch(2, 0) !== -1 || hs_q.size() !== 2 * exp_steps.size())
            $display("FAIL backpressure_seq: mismatch index %0d, %0d handshakes required -1 and %0d", log_mismatch(2, 0), hs_q.size(), 2 * exp_steps.size());
        else n_pass++;
        n_checks++;
        if (done_cnt !== 1) $display("FAIL backpressure_done: got %0d required 1", done_cnt); else n_pass++;
    endtask

    task automatic test_repeat();
        int dw, deff;
        dw = $urandom_range(0, 2); deff = (dw == 0) ? 1 : dw;
        build_steps(10, 25, 10, 0);
        start_sweep(10, 25, 10, dw, 1);
        collect(80, 2, 0, -1);
        n_checks++;
        if (hs_q.size() < 4) $display("FAIL repeat_count: got %0d handshakes required at least 4", hs_q.size()); else n_pass++;
        n_checks++;
        if (log_mismatch(deff, 1) !== -1) $display("FAIL repeat_seq: first wrong index %0d required -1 (dwell %0d)", log_mismatch(deff, 1), dw); else n_pass++;
        n_checks++;
        if (done_cnt !== 0 || en_busy_err !== 0) $display("FAIL repeat_done: got done=%0d en/busy err=%0d required 0/0", done_cnt, en_busy_err); else n_pass++;
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        n_checks++;
        if ({busy_o, ctrl_en_o, done_o} !== 3'b000) $display("FAIL repeat_abort: got busy/en/done=%b required 000", {busy_o, ctrl_en_o, done_o}); else n_pass++;
    endtask

    task automatic test_edges();
        int tab[5][4] = '{'{10, 25, 10, 0}, '{50, 200, 0, 2}, '{300, 100, 10, 2},
                          '{65000, 65535, 600, 1}, '{5, 65535, 65530, 1}};
        for (int t = 0; t < 5; t++) begin
            int deff;
            deff = (tab[t][3] == 0) ? 1 : tab[t][3];
            build_steps(tab[t][0], tab[t][1], tab[t][2], 0);
            start_sweep(tab[t][0], tab[t][1], tab[t][2], tab[t][3], 0);
            collect(300, 2, 1, -1);
            n_checks++;
            if (timed_out || done_cnt !== 1) $display("FAIL edge%0d_done: timeout=%0b done cycles=%0d required 0/1", t, timed_out, done_cnt); else n_pass++;
            n_checks++;
            if (hs_q.size() !== deff * exp_steps.size() || log_mismatch(deff, 0) !== -1)
                $display("FAIL edge%0d_seq: %0d handshakes mismatch index %0d required %0d and -1", t, hs_q.size(), log_mismatch(deff, 0), deff * exp_steps.size());
            else n_pass++;
        end
    endtask

    task automatic test_abort_start();
        @(negedge clk);
        cfg_start = 16'd100; cfg_stop = 16'd400; cfg_step = 16'd100; cfg_dwell = 16'd1; cfg_repeat = 1'b0;
        start_i = 1'b1; abort_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; abort_i = 1'b0;
        n_checks++;
        if ({busy_o, ctrl_en_o} !== 2'b00) $display("FAIL collide_idle: got busy/en=%b required 00", {busy_o, ctrl_en_o}); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (busy_o !== 1'b0) $display("FAIL collide_idle_late: got busy=%b required 0", busy_o); else n_pass++;

        start_sweep(100, 400, 100, 5, 0);
        collect(7, 0, 0, -1);
        abort_i = 1'b1;
        if ($urandom % 2) start_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0; start_i = 1'b0;
        n_checks++;
        if ({busy_o, ctrl_en_o, done_o} !== 3'b000) $display("FAIL abort_mid: got busy/en/done=%b required 000", {busy_o, ctrl_en_o, done_o}); else n_pass++;
        collect(20, 0, 0, -1);
        n_checks++;
        if (done_cnt !== 0 || hs_q.size() !== 0) $display("FAIL abort_after: got done=%0d logged=%0d required 0/0", done_cnt, hs_q.size()); else n_pass++;

        build_steps(100, 400, 100, 0);
        start_sweep(100, 400, 100, 2, 0);
        collect(200, 0, 1, 4);
        n_checks++;
        if (hs_q.size() !== 8 || log_mismatch(2, 0) !== -1)
            $display("FAIL start_in_run: %0d handshakes mismatch index %0d required 8 and -1", hs_q.size(), log_mismatch(2, 0));
        else n_pass++;
        n_checks++;
        if (done_cnt !== 1) $display("FAIL start_in_run_done: got %0d required 1", done_cnt); else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int s, e, st, dw, deff;
            s = $urandom_range(0, 500); e = $urandom_range(0, 900);
            st = $urandom_range(20, 150); dw = $urandom_range(0, 3);
            deff = (dw == 0) ? 1 : dw;
            build_steps(s, e, st, 0);
            start_sweep(s, e, st, dw, 0);
            collect(3000, 2, 1, -1);
            n_checks++;
            if (timed_out || done_cnt !== 1 || en_busy_err !== 0)
                $display("FAIL random%0d_done: timeout=%0b done=%0d en/busy err=%0d required 0/1/0", it, timed_out, done_cnt, en_busy_err);
            else n_pass++;
            n_checks++;
            if (hs_q.size() !== deff * exp_steps.size() || log_mismatch(deff, 0) !== -1)
                $display("FAIL random%0d_seq: start=%0d stop=%0d step=%0d dwell=%0d got %0d handshakes mismatch %0d required %0d and -1",
                         it, s, e, st, dw, hs_q.size(), log_mismatch(deff, 0), deff * exp_steps.size());
            else n_pass++;
        end
    endtask

`ifdef WFG_SWEEP_BIDIR_EN
    task automatic test_bidir();
        cfg_bidir = 1'b1;
        build_steps(100, 300, 100, 1);
        start_sweep(100, 300, 100, 1, 0);
        collect(200, 0, 1, -1);
        n_checks++;
        if (timed_out || done_cnt !== 1 || hs_q.size() !== 5 || log_mismatch(1, 0) !== -1)
            $display("FAIL bidir_basic: %0d handshakes mismatch %0d done=%0d required 5, -1, 1", hs_q.size(), log_mismatch(1, 0), done_cnt);
        else n_pass++;
        for (int it = 0; it < 3; it++) begin
            int s, e, st, dw, deff;
            s = $urandom_range(0, 400); e = $urandom_range(0, 900);
            st = $urandom_range(30, 150); dw = $urandom_range(0, 2);
            deff = (dw == 0) ? 1 : dw;
            build_steps(s, e, st, 1);
            start_sweep(s, e, st, dw, 0);
            collect(3000, 2, 1, -1);
            n_checks++;
            if (timed_out || done_cnt !== 1 || hs_q.size() !== deff * exp_steps.size() || log_mismatch(deff, 0) !== -1)
                $display("FAIL bidir_random%0d: %0d handshakes mismatch %0d done=%0d required %0d, -1, 1",
                         it, hs_q.size(), log_mismatch(deff, 0), done_cnt, deff * exp_steps.size());
            else n_pass++;
        end
        cfg_bidir = 1'b0;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        cfg_start = '0; cfg_stop = '0; cfg_step = '0; cfg_dwell = '0; cfg_repeat = 1'b0;
`ifdef WFG_SWEEP_BIDIR_EN
        cfg_bidir = 1'b0;
`endif
        start_i = 1'b0; abort_i = 1'b0; tvalid = 1'b0; tready = 1'b0;
        test_reset();
        test_single_shot();
        test_backpressure();
        test_repeat();
        test_edges();
        test_abort_start();
        test_random();
`ifdef WFG_SWEEP_BIDIR_EN
        test_bidir();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
